cmp3_result_tracker: RTL

Downstream consumer of the 3-bit comparator/code-converter stage. Accepts a stream of operand pairs `a`/`b` together with the comparator's `more`/`less`/`no_relation` flags under a valid/ready handshake. Accumulates outcome statistics over a fixed window of samples and presents one registered summary report per window under a second valid/ready handshake. Sits between the combinational comparator and any display or logging logic.

---
 rtl/cmp3_result_tracker.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cmp3_result_tracker.sv
// rtl/cmp3_result_tracker.sv - windowed outcome statistics for the 3-bit comparator stage
//
// Collects up to WINDOW accepted comparator results and presents one held
// summary report per window. Optional flag self-check: CMP3_SELF_CHECK_EN.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   enable             level, permits accumulation (low discards a partial window)
//   flush              pulse, reports a non-empty partial window early
//   in_valid/in_ready  sample handshake; in_ready is a registered state decode
//   a, b               operand pair seen by the comparator
//   more, less,
//   no_relation        comparator flags for a/b
//   report_valid/
//   report_ready       report handshake; outputs are frozen while report_valid
//   gt_cnt, lt_cnt,
//   eq_cnt, sample_cnt outcome counts for the window
//   max_diff           largest |a-b| seen in the window
//   mismatch_cnt       flag/operand disagreements (0 unless self-check built in)
module cmp3_result_tracker #(
  parameter int unsigned WINDOW = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       more,
  input  logic       less,
  input  logic       no_relation,
  output logic       report_valid,
  input  logic       report_ready,
  output logic [7:0] gt_cnt,
  output logic [7:0] lt_cnt,
  output logic [7:0] eq_cnt,
  output logic [7:0] sample_cnt,
  output logic [2:0] max_diff,
  output logic [7:0] mismatch_cnt
);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  localparam logic [7:0] WIN = 8'(WINDOW);

  state_t     state, next_state;
  logic       clear_acc;
  logic       accept;
  logic       win_done;
  logic       flush_go;
  logic       is_gt, is_lt;
  logic [3:0] diff4;
  logic [2:0] diff3;

  logic [7:0] gt_q, lt_q, eq_q, smp_q;
  logic [2:0] max_q;

  assign in_ready     = (state == ACCUM);
  assign report_valid = (state == REPORT);
  assign accept       = in_valid && in_ready;

  // Contradictory or absent flags (both set, neither set, no_relation) count as EQ.
  assign is_gt = more && !less;
  assign is_lt = less && !more;

  assign diff4 = (a > b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  assign diff3 = diff4[2:0];

  assign win_done = accept && ((smp_q + 8'd1) == WIN);
  // A sample arriving with the flush makes an otherwise empty window reportable.
  assign flush_go = flush && ((smp_q != 8'd0) || accept);

  always_comb begin
    next_state = state;
    clear_acc  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) next_state = ACCUM;
      end
      ACCUM: begin
        // Completing or flushing a window wins over enable falling.
        if (win_done || flush_go) begin
          next_state = REPORT;
        end else if (!enable) begin
          next_state = IDLE;
          clear_acc  = 1'b1;
        end
      end
      REPORT: begin
        if (report_ready) begin
          clear_acc  = 1'b1;
          next_state = enable ? ACCUM : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        clear_acc  = 1'b1;
      end
    endcase
  end

`ifdef CMP3_SELF_CHECK_EN
  logic [7:0] mis_q;
  logic       flag_bad;

  assign flag_bad = (more != (a > b)) || (less != (a < b)) || (no_relation != (a == b));
  assign mismatch_cnt = mis_q;

  always_ff @(posedge clk) begin
    if (rst || clear_acc) begin
      mis_q <= 8'd0;
    end else if (accept && flag_bad && (mis_q != 8'hFF)) begin
      mis_q <= mis_q + 8'd1;
    end
  end
`else
  logic unused_flags;

  assign unused_flags = no_relation;
  assign mismatch_cnt = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gt_q  <= 8'd0;
      lt_q  <= 8'd0;
      eq_q  <= 8'd0;
      smp_q <= 8'd0;
      max_q <= 3'd0;
    end else begin
      state <= next_state;
      if (clear_acc) begin
        // Also drops a sample accepted in the same cycle enable falls.
        gt_q  <= 8'd0;
        lt_q  <= 8'd0;
        eq_q  <= 8'd0;
        smp_q <= 8'd0;
        max_q <= 3'd0;
      end else if (accept) begin
        smp_q <= smp_q + 8'd1;
        if (is_gt)      gt_q <= gt_q + 8'd1;
        else if (is_lt) lt_q <= lt_q + 8'd1;
        else            eq_q <= eq_q + 8'd1;
        if (diff3 > max_q) max_q <= diff3;
      end
    end
  end

  assign gt_cnt     = gt_q;
  assign lt_cnt     = lt_q;
  assign eq_cnt     = eq_q;
  assign sample_cnt = smp_q;
  assign max_diff   = max_q;

endmodule
